// File: rtl/frame_capture_ctrl.sv
// Capture sequencer: arms on a vsync edge and forwards exactly IMG_WIDTH x IMG_HEIGHT pixels per frame.
// The latency is one cycle. There is no backpressure, and the block accepts one pixel per cycle.
module frame_capture_ctrl #(
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480,
    parameter int PIXEL_WIDTH       = 8,
    parameter int FRAMES_TO_CAPTURE = 1,
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_vsync,
    input  logic                   i_data_valid,
    input  logic [PIXEL_WIDTH-1:0] i_data_r,
    input  logic [PIXEL_WIDTH-1:0] i_data_g,
    input  logic [PIXEL_WIDTH-1:0] i_data_b,
    output logic                   o_data_valid,
    output logic [PIXEL_WIDTH-1:0] o_data_r,
    output logic [PIXEL_WIDTH-1:0] o_data_g,
    output logic [PIXEL_WIDTH-1:0] o_data_b,
    output logic [XW-1:0]          o_x,
    output logic [YW-1:0]          o_y,
    output logic                   o_sof,
    output logic                   o_eol,
    output logic                   o_eof,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [31:0]            o_frame_count,
    output logic                   o_err_short,
    output logic                   o_err_long
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [31:0]   F_LAST = 32'(FRAMES_TO_CAPTURE);

    state_t                 state_q, state_d;
    logic                   vsync_q;
    logic                   after_frame_q, after_frame_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [31:0]            count_q, count_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic                   vld_q, vld_d;
    logic [PIXEL_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [XW-1:0]          ox_q, ox_d;
    logic [YW-1:0]          oy_q, oy_d;
    logic                   sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                   busy_q, busy_d, done_q, done_d;

    logic                   vsync_edge;
    logic                   px_en;
    logic [XW-1:0]          cx;
    logic [YW-1:0]          cy;

    assign vsync_edge = i_vsync & ~vsync_q;

    always_comb begin
        state_d       = state_q;
        after_frame_d = after_frame_q;
        x_d           = x_q;
        y_d           = y_q;
        count_d       = count_q;
        err_short_d   = err_short_q;
        err_long_d    = err_long_q;
        vld_d         = 1'b0;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        sof_d         = 1'b0;
        eol_d         = 1'b0;
        eof_d         = 1'b0;
        px_en         = 1'b0;
        cx            = x_q;
        cy            = y_q;

        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_d       = S_ARM;
                        count_d       = '0;
                        err_short_d   = 1'b0;
                        err_long_d    = 1'b0;
                        after_frame_d = 1'b0;
                    end
                end
                S_ARM: begin
                    if (vsync_edge) begin
                        state_d = S_CAPTURE;
                        px_en   = 1'b1;
                        cx      = '0;
                        cy      = '0;
                    end else if (i_data_valid && after_frame_q) begin
                        err_long_d = 1'b1;
                    end
                end
                S_CAPTURE: begin
                    px_en = 1'b1;
                    // A new frame started before this one finished.
                    if (vsync_edge) begin
                        err_short_d = 1'b1;
                        cx          = '0;
                        cy          = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (px_en) begin
                x_d = cx;
                y_d = cy;
                if (i_data_valid) begin
                    vld_d = 1'b1;
                    r_d   = i_data_r;
                    g_d   = i_data_g;
                    b_d   = i_data_b;
                    ox_d  = cx;
                    oy_d  = cy;
                    sof_d = (cx == '0) && (cy == '0);
                    eol_d = (cx == X_LAST);
                    if ((cx == X_LAST) && (cy == Y_LAST)) begin
                        eof_d         = 1'b1;
                        count_d       = count_q + 32'd1;
                        x_d           = '0;
                        y_d           = '0;
                        after_frame_d = 1'b1;
                        state_d       = (count_q + 32'd1 == F_LAST) ? S_DONE : S_ARM;
                    end else if (cx == X_LAST) begin
                        x_d = '0;
                        y_d = cy + 1'b1;
                    end else begin
                        x_d = cx + 1'b1;
                    end
                end
            end
        end

        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            vsync_q       <= 1'b1;
            after_frame_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            count_q       <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            vld_q         <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= i_vsync;
            after_frame_q <= after_frame_d;
            x_q           <= x_d;
            y_q           <= y_d;
            count_q       <= count_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            vld_q         <= vld_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_data_valid  = vld_q;
    assign o_data_r      = r_q;
    assign o_data_g      = g_q;
    assign o_data_b      = b_q;
    assign o_x           = ox_q;
    assign o_y           = oy_q;
    assign o_sof         = sof_q;
    assign o_eol         = eol_q;
    assign o_eof         = eof_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_frame_count = count_q;
    assign o_err_short   = err_short_q;
    assign o_err_long    = err_long_q;

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Synthesizable capture sequencer between the bilinear-scaler output stream and the frame sink (simulation dumper or memory writer). On a start command it arms on the next frame boundary, forwards exactly IMG_WIDTH×IMG_HEIGHT valid pixels per frame with coordinates and frame markers, counts completed frames, and stops after FRAMES_TO_CAPTURE frames. Malformed frames (too short or too long) are flagged and never delivered as complete frames.

## Interface
- IMG_WIDTH, 640, active pixels per line
- IMG_HEIGHT, 480, active lines per frame
- PIXEL_WIDTH, 8, bits per colour component
- FRAMES_TO_CAPTURE, 1, frames per start command (≥1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse; begin a capture run
- i_abort  in  1  one-cycle pulse; abandon the run
- i_vsync  in  1  frame sync, active high; rising edge marks frame start
- i_data_valid  in  1  input pixel qualifier
- i_data_r / i_data_g / i_data_b  in  PIXEL_WIDTH each  pixel components (r = gray in grayscale)
- o_data_valid  out  1  forwarded pixel qualifier
- o_data_r / o_data_g / o_data_b  out  PIXEL_WIDTH each  forwarded components
- o_x  out  $clog2(IMG_WIDTH)  column of forwarded pixel
- o_y  out  $clog2(IMG_HEIGHT)  line of forwarded pixel
- o_sof / o_eol / o_eof  out  1 each  first pixel of frame / last pixel of line / last pixel of frame
- o_busy  out  1  high in ARM or CAPTURE
- o_done  out  1  high in DONE
- o_frame_count  out  32  completed frames in current run
- o_err_short / o_err_long  out  1 each  sticky frame-length errors

## Operation
- vsync edge = i_vsync & ~vsync_d; vsync_d resets to 1 (no spurious edge when vsync is high at reset release).
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: i_start → ARM; clears o_frame_count, o_err_short, o_err_long.
- ARM: waits for vsync edge → CAPTURE with x=y=0. A pixel valid in the edge cycle is pixel (0,0). Valid pixels in ARM without an edge are dropped; if ARM was entered from a completed frame, each such pixel sets o_err_long.
- CAPTURE: each valid pixel is forwarded with current (x,y); x increments, wraps to 0 at IMG_WIDTH-1 and y increments. At (IMG_WIDTH-1, IMG_HEIGHT-1): o_eof, o_frame_count+1; next state DONE if new count == FRAMES_TO_CAPTURE, else ARM.
- Short frame: vsync edge in CAPTURE before the final pixel → o_err_short set, count unchanged, counters reset to 0, remain in CAPTURE (new frame begins; same-cycle valid pixel is its (0,0) with o_sof).
- DONE: input ignored; i_start → ARM with counters and errors cleared.
- i_abort from any state → IDLE; o_frame_count and errors held. Abort and start in the same cycle: abort wins.
- Invalid input cycles do not advance x/y; gaps anywhere in a frame are legal.
- Data outputs hold last value when o_data_valid is low.

## Timing
- All outputs registered; reset value 0 for every output.
- Latency: input pixel at edge n appears with o_data_valid at edge n+1; o_x/o_y/o_sof/o_eol/o_eof aligned with it.
- o_frame_count increments and o_done rises in the same cycle as the final o_eof.
- o_busy rises the cycle after i_start; falls the cycle after i_abort or together with final o_eof.
- After i_abort, o_data_valid is low from the next cycle; a pixel presented in the abort cycle is dropped.
- Reset mid-frame: all state to IDLE immediately (asynchronous); no partial frame completion reported.
- Throughput: one pixel per cycle sustained, no backpressure.

## Test plan
- Use IMG_WIDTH=4, IMG_HEIGHT=3, FRAMES_TO_CAPTURE=2.
- Normal run: start, vsync, 12 back-to-back pixels, vsync, 12 pixels → 24 o_data_valid, (x,y) sequence (0,0)…(3,2) twice, o_eol on x=3, o_eof twice, o_frame_count=2, o_done=1, o_busy=0, errors 0.
- Gating: pixels before i_start and in ARM before the first vsync → no o_data_valid, o_err_long=0; pixels with valid toggling every other cycle → coordinates contiguous.
- Short frame: 7 pixels then vsync edge plus valid → o_err_short=1, count stays 0, that pixel emitted as (0,0) with o_sof; next 12 pixels complete frame 1.
- Long frame: 14 pixels after one vsync → first 12 forwarded, 2 dropped, o_err_long=1, o_frame_count=1.
- Abort/reset: i_abort at pixel 5 → o_data_valid low next cycle, state IDLE, count held; new i_start clears count/errors; rst_n pulse mid-frame → all outputs 0.
